spi_prefetch_fifo: RTL and testbench
====================================

SPI_PREFETCH_FIFO -- requirements
Module: spi_prefetch_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH_BYTES, default 2, word width in bytes (W = 8*DATA_WIDTH_BYTES).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous active-low reset.
REQ-005 SHALL have port start_read  input  1  consumer one-cycle pulse: flush, begin new stream.
REQ-006 SHALL have port stop_read  input  1  consumer one-cycle pulse: flush, end stream.
REQ-007 SHALL have port pop  input  1  consumer takes head word this cycle.
REQ-008 SHALL have port data_out  output  W  head word, valid when data_valid=1.
REQ-009 SHALL have port data_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  stored word count.
REQ-011 SHALL have port underflow  output  1  sticky: pop seen while empty.
REQ-012 SHALL have port spi_start_read  output  1  pulse to flash controller: start read (fetches first word).
REQ-013 SHALL have port spi_continue_read  output  1  pulse to flash controller: fetch next word.
REQ-014 SHALL have port spi_stop_read  output  1  pulse to flash controller: end read.
REQ-015 SHALL have port spi_data  input  W  controller word, valid when busy falls after request.
REQ-016 SHALL have port spi_busy  input  1  controller busy.

Function
REQ-017 SHALL implement states IDLE and ACTIVE; reset -> IDLE.
REQ-018 IDLE: start_read -> ACTIVE, same cycle flush FIFO, spi_start_read=1 combinationally, inflight<=1, seen_busy<=0.
REQ-019 ACTIVE: stop_read -> IDLE, flush FIFO, spi_stop_read=1, inflight<=0, seen_busy<=0.
REQ-020 ACTIVE: start_read (restart) SHALL flush, pulse spi_start_read, inflight<=1, seen_busy<=0; any pending word of the old stream is discarded.
REQ-021 start_read and stop_read in same cycle: stop_read wins.
REQ-022 IDLE: stop_read SHALL still pulse spi_stop_read, flush; no state change.
REQ-023 seen_busy SHALL set when inflight=1 and spi_busy=1.
REQ-024 Capture: inflight=1, seen_busy=1, spi_busy=0 -> write spi_data at tail, inflight<=0, seen_busy<=0; one word per capture.
REQ-025 Request: ACTIVE, inflight=0, no capture this cycle, no start/stop, level + pending < DEPTH -> spi_continue_read=1 one cycle, inflight<=1; at most one outstanding request.
REQ-026 Slot reservation: requests SHALL never be issued when a capture would overflow; write-when-full is unreachable.
REQ-027 data_out SHALL be registered storage at head, zero-latency (FWFT): word captured in cycle N visible with data_valid=1 in N+1.
REQ-028 pop with data_valid=1 SHALL advance head; simultaneous pop and capture keeps level unchanged.
REQ-029 pop with data_valid=0 SHALL be ignored and set underflow; cleared only by reset or start_read.
REQ-030 Flush (start/stop) in same cycle as capture or pop: flush wins, captured/popped word dropped, level<=0.
REQ-031 Pointers SHALL be $clog2(DEPTH) bits, wrap modulo DEPTH; level = write count - read count, 0..DEPTH.
REQ-032 spi_* outputs SHALL be combinational pulses, never asserted two consecutive cycles except start_read held by consumer.

Reset
REQ-033 rstn=0 SHALL force: IDLE, level=0, data_valid=0, underflow=0, inflight=0, seen_busy=0, pointers=0, all spi_* outputs 0 in the same cycle.
REQ-034 data_out reset value SHALL be 0; storage contents need not be reset.
REQ-035 Reset mid-transfer SHALL abandon inflight request without issuing spi_stop_read.

Verification
REQ-036 Fill: DEPTH=4, start_read, controller model busy 3 cycles per word, no pop -> exactly 4 words captured, one spi_start_read + 3 spi_continue_read, level=4, no further requests.
REQ-037 Stream: pop every cycle data_valid=1, words 0x0001..0x0010 -> data_out order 0x0001..0x0010, no loss/duplicate, level never >4.
REQ-038 Simultaneous: level=2, capture and pop same cycle -> level stays 2, head advances.
REQ-039 Restart: ACTIVE, inflight, level=3, start_read -> level=0 next cycle, spi_start_read=1, old in-flight word never appears.
REQ-040 Underflow: pop at level=0 -> underflow=1, level=0; start_read clears it.
REQ-041 Reset: rstn=0 mid-capture with level=2 -> next cycle level=0, data_valid=0, IDLE, no spi_* pulse.

Source files
------------

// File: rtl/spi_prefetch_fifo.sv
// Prefetching read FIFO in front of a word-serial SPI flash controller.
// Keeps at most one word request outstanding and only asks when a free slot is guaranteed.
module spi_prefetch_fifo #(
  parameter int unsigned DATA_WIDTH_BYTES = 2,
  parameter int unsigned DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start_read,
  input  logic                        stop_read,
  input  logic                        pop,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                        data_valid,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        underflow,
  output logic                        spi_start_read,
  output logic                        spi_continue_read,
  output logic                        spi_stop_read,
  input  logic [8*DATA_WIDTH_BYTES-1:0] spi_data,
  input  logic                        spi_busy
);

  localparam int unsigned W    = 8 * DATA_WIDTH_BYTES;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

  typedef enum logic {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   level_q, level_d;
  logic            inflight_q, inflight_d;
  logic            seen_busy_q, seen_busy_d;
  logic            underflow_q, underflow_d;
  logic            flush, capture, pop_ok, empty;

  always_comb begin
    empty   = (level_q == '0);
    flush   = start_read | stop_read;
    capture = inflight_q & seen_busy_q & ~spi_busy;
    pop_ok  = pop & ~empty;

    // Request pulses are gated by reset so nothing leaks to the controller while in reset.
    spi_stop_read     = rstn & stop_read;
    spi_start_read    = rstn & start_read & ~stop_read;
    spi_continue_read = rstn & (state_q == StActive) & ~inflight_q & ~capture & ~flush &
                        (level_q < Full);

    data_valid = ~empty;
    data_out   = empty ? '0 : mem_q[rd_ptr_q];
    level      = level_q;
    underflow  = underflow_q;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    inflight_d  = inflight_q;
    seen_busy_d = seen_busy_q;
    underflow_d = (underflow_q | (pop & empty)) & ~start_read;

    if (inflight_q && spi_busy) seen_busy_d = 1'b1;
    if (capture) begin
      inflight_d  = 1'b0;
      seen_busy_d = 1'b0;
      wr_ptr_d    = wr_ptr_q + PtrW'(1);
    end
    if (spi_continue_read) inflight_d = 1'b1;
    if (pop_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);

    case ({capture, pop_ok})
      2'b10:   level_d = level_q + (PtrW + 1)'(1);
      2'b01:   level_d = level_q - (PtrW + 1)'(1);
      default: level_d = level_q;
    endcase

    // Flush beats any capture or pop in the same cycle; stop beats start.
    if (stop_read) begin
      state_d     = StIdle;
      inflight_d  = 1'b0;
      seen_busy_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
    end else if (start_read) begin
      state_d     = StActive;
      inflight_d  = 1'b1;
      seen_busy_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      inflight_q  <= 1'b0;
      seen_busy_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      seen_busy_q <= seen_busy_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && capture && !flush) mem_q[wr_ptr_q] <= spi_data;
  end

endmodule

// File: tb/tb_spi_prefetch_fifo.sv
// Randomized bench for spi_prefetch_fifo: a queue-based FIFO model plus a simple
// flash-controller model that answers each request after a random busy time.
module tb_spi_prefetch_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 16;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start_read = 1'b0;
  logic         stop_read = 1'b0;
  logic         pop = 1'b0;
  logic         spi_busy = 1'b0;
  logic [W-1:0] spi_data = '0;
  logic [W-1:0] data_out;
  logic         data_valid, underflow;
  logic         spi_start_read, spi_continue_read, spi_stop_read;
  logic [2:0]   level;

  always #5 clk = ~clk;

  spi_prefetch_fifo #(
    .DATA_WIDTH_BYTES(2),
    .DEPTH           (DEPTH)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start_read       (start_read),
    .stop_read        (stop_read),
    .pop              (pop),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .level            (level),
    .underflow        (underflow),
    .spi_start_read   (spi_start_read),
    .spi_continue_read(spi_continue_read),
    .spi_stop_read    (spi_stop_read),
    .spi_data         (spi_data),
    .spi_busy         (spi_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, stream state, one-outstanding-request flag, sticky underflow.
  logic [W-1:0] q[$];
  bit           active = 0;
  bit           outstanding = 0;
  bit           uflow = 0;

  // Controller model.
  int           busy_cnt = 0;
  int           lat = 3;
  bit           deliver_now = 0;
  logic [W-1:0] cur_word = '0;
  logic [W-1:0] next_word = 16'h0001;
  int           n_start = 0;
  int           n_cont = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at negedge, advance model, let controller react after posedge.
  task automatic cycle();
    bit e_start, e_stop, e_cont, o_start, o_cont, o_stop;
    @(negedge clk);
    e_stop  = rstn && stop_read;
    e_start = rstn && start_read && !stop_read;
    e_cont  = rstn && active && !outstanding && !start_read && !stop_read && (q.size() < DEPTH);
    check("spi_start_read", spi_start_read, e_start);
    check("spi_stop_read", spi_stop_read, e_stop);
    check("spi_continue_read", spi_continue_read, e_cont);
    check("level", level, q.size());
    check("data_valid", data_valid, q.size() != 0);
    if (q.size() != 0) check("data_out", data_out, q[0]);
    check("underflow", underflow, uflow);
    o_start = spi_start_read;
    o_cont  = spi_continue_read;
    o_stop  = spi_stop_read;
    n_start += int'(o_start);
    n_cont  += int'(o_cont);

    if (!rstn) begin
      q.delete();
      active = 0;
      outstanding = 0;
      uflow = 0;
    end else begin
      if (pop && q.size() == 0) uflow = 1;
      if (start_read) uflow = 0;
      if (start_read || stop_read) begin
        q.delete();
        active = !stop_read;
        outstanding = !stop_read;
      end else begin
        if (pop && q.size() != 0) void'(q.pop_front());
        if (deliver_now && outstanding) begin
          q.push_back(cur_word);
          outstanding = 0;
        end
        if (e_cont) outstanding = 1;
      end
    end

    @(posedge clk);
    #1;
    deliver_now = 0;
    if (o_start || o_cont) begin
      busy_cnt = lat;
      cur_word = next_word;
      next_word++;
    end else if (o_stop) begin
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      deliver_now = (busy_cnt == 0);
    end
    spi_busy = (busy_cnt > 0);
    spi_data = deliver_now ? cur_word : W'($urandom);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cycle();
    check("rst_data_out", data_out, 0);
    check("rst_level", level, 0);
    rstn = 1'b1;

    // Pop while empty sets the sticky flag; it survives idle cycles.
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    cycle();
    check("underflow_set", underflow, 1);

    // Fill with no consumer: one start, three continues, then stall at DEPTH.
    lat = 3;
    n_start = 0;
    n_cont = 0;
    start_read = 1'b1;
    cycle();
    start_read = 1'b0;
    check("underflow_clr", underflow, 0);
    repeat (40) cycle();
    check("fill_starts", n_start, 1);
    check("fill_conts", n_cont, 3);
    check("fill_level", level, 4);

    // Stream: drain whenever valid; words come out in order 0x0001 upwards.
    check("stream_head", data_out, 16'h0001);
    for (int i = 0; i < 120; i++) begin
      pop = (q.size() != 0);
      cycle();
    end
    pop = 1'b0;

    // Restart with level 3 and a request in flight.
    for (int i = 0; i < 40 && q.size() < DEPTH; i++) cycle();
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    for (int i = 0; i < 10 && !spi_busy; i++) cycle();
    check("restart_busy", spi_busy, 1);
    check("restart_pre_level", level, 3);
    start_read = 1'b1;
    cycle();
    start_read = 1'b0;
    check("restart_level", level, 0);

    // Reset with two words stored and a capture on its way.
    for (int i = 0; i < 40 && q.size() < 2; i++) cycle();
    check("rst_pre_level", level, 2);
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    check("rst_mid_level", level, 0);
    check("rst_mid_valid", data_valid, 0);
    repeat (8) cycle();

    // Random mix of pops, restarts, stops, resets and controller latencies.
    for (int i = 0; i < 3000; i++) begin
      lat        = $urandom_range(1, 4);
      pop        = ($urandom_range(0, 99) < 50);
      start_read = ($urandom_range(0, 99) < 3);
      stop_read  = ($urandom_range(0, 99) < 2);
      rstn       = ($urandom_range(0, 199) != 0);
      if (!active && $urandom_range(0, 9) == 0) start_read = 1'b1;
      cycle();
    end
    start_read = 1'b0;
    stop_read = 1'b0;
    pop = 1'b0;
    rstn = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
